inst_fetch: RTL

- Fetch stage directly upstream of the decode/execute datapath in `cpu`.
- Issues word-aligned requests to instruction memory over a request/grant and in-order response interface.
- Buffers returned words with their PCs in a small queue; presents them to decode over a valid/ready handshake.
- Accepts a single-cycle redirect (taken branch) that flushes queued and in-flight instructions, then restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/inst_fetch_sync_fifo.sv | 62 ++++++
 rtl/inst_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and FSM encoding for the instruction fetch
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default first fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Clears the byte offset so every fetch address is word aligned
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Fetch stride in bytes
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Fetch control states
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with push, pop, flush and occupancy count.
//               Head data is a direct read of the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and count bookkeeping; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage. Issues word requests under a credit
//               limit, tags responses with their PC, buffers them and hands
//               them to decode. A redirect flushes everything and turns the
//               still-pending responses into drops.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic            fetch_en;

  logic [31:0]     fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_redirect;
  logic [SW-1:0]   credit_used;

  logic            issue;
  logic            resp_live;
  logic            resp_drop;
  logic            head_pop;
  logic            slot_free;
  logic            load_from_q;
  logic            load_from_resp;

  logic            q_push;
  logic [63:0]     q_head;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;

  logic [31:0]     tag_head;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;

  // Credit accounting keeps both FIFOs from overflowing or underflowing,
  // so their status flags are not consulted.
  logic            unused_bits;
  assign unused_bits = ^{q_full, tag_full, tag_empty, tag_count, redirect_pc[1:0]};

  assign issue     = imem_req & imem_gnt;
  // A response during a redirect is always stale, so it is never accepted
  assign resp_live = imem_rvalid & (drop == '0) & ~redirect;
  assign resp_drop = imem_rvalid & (drop != '0);
  assign head_pop  = inst_valid & inst_ready;
  assign slot_free = ~inst_valid | head_pop;

  // The output register is refilled from the queue first; a response only
  // bypasses straight to it when nothing older is waiting.
  assign load_from_q    = slot_free & ~q_empty & ~redirect;
  assign load_from_resp = slot_free & q_empty & resp_live;
  assign q_push         = resp_live & ~load_from_resp;

  // Every slot is reserved at issue: queued, in flight, or awaiting drop
  assign credit_used = SW'(q_count) + SW'(inst_valid) + SW'(outstanding) + SW'(drop);
  assign imem_req    = fetch_en & (credit_used < SW'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign drop_redirect = outstanding + drop + CW'(issue) - CW'(imem_rvalid);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_inst_q (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({tag_head, imem_rdata}),
    .pop       (load_from_q),
    .flush     (redirect),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (resp_live),
    .flush     (redirect),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  // FSM next state: one idle cycle after reset, then run forever
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // FSM outputs: fetching is only permitted in RUN
  always_comb begin
    fetch_en = 1'b0;
    if (state == RUN) fetch_en = 1'b1;
  end

  // Fetch PC, in-flight and drop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc & WORD_ALIGN_MASK;
      outstanding <= '0;
      drop        <= drop_redirect;
    end else begin
      if (issue) fetch_pc <= fetch_pc + WORD_BYTES;
      outstanding <= outstanding + CW'(issue) - CW'(resp_live);
      drop        <= drop - CW'(resp_drop);
    end
  end

  // Registered head presented to decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
    end else if (load_from_q) begin
      inst_valid <= 1'b1;
      inst_pc    <= q_head[63:32];
      inst       <= q_head[31:0];
    end else if (load_from_resp) begin
      inst_valid <= 1'b1;
      inst_pc    <= tag_head;
      inst       <= imem_rdata;
    end else if (head_pop) begin
      inst_valid <= 1'b0;
    end
  end

endmodule : inst_fetch
`default_nettype wire
